// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny hysteresis stage.
// Pixel classes travel through the line buffers as 2-bit codes.
package canny_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } pix_class_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } hyst_state_t;

    localparam logic [7:0] EDGE_ON = 8'd255;

endpackage

// File: rtl/hysteresis_threshold_if.sv
// Input magnitude stream and output edge-map stream of the hysteresis stage.
// master = producer/consumer side, slave = the hysteresis block.
interface hysteresis_threshold_if #(
    parameter int PIX_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_pixel;
    logic             out_last;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_last
    );
endinterface

// File: rtl/class_line_buffer.sv
// DEPTH-deep circular delay line of pixel classes; dout is the class written
// DEPTH advances ago and is replaced by din on each advance.
module class_line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  pix_class_t din,
    output pix_class_t dout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    pix_class_t       mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; stale contents only ever reach border outputs, which are forced to 0.
    always_ff @(posedge clk) begin
        if (advance) begin
            mem[ptr] <= din;
        end
    end
endmodule

// File: rtl/hysteresis_threshold.sv
// Streaming double threshold + single-pass hysteresis: a 3x3 class window fed by
// two line buffers; the output is the window centre, WIDTH+1 pixels behind input.
module hysteresis_threshold
    import canny_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5,
    parameter int PIX_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PIX_W-1:0]       high_thr,
    input  logic [PIX_W-1:0]       low_thr,
    hysteresis_threshold_if.slave  strm,
    output logic                   busy,
    output logic                   done
);
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(NPIX + WIDTH + 2);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    localparam logic [CNT_W-1:0] FIRST_OUT = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] LAST_ADV  = CNT_W'(NPIX + WIDTH);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);

    function automatic pix_class_t classify(input logic [PIX_W-1:0] p,
                                            input logic [PIX_W-1:0] hi,
                                            input logic [PIX_W-1:0] lo);
        if (p >= hi)      return CLS_STRONG;
        else if (p >= lo) return CLS_WEAK;
        else              return CLS_NONE;
    endfunction

    hyst_state_t      state, state_nxt;
    logic [PIX_W-1:0] hi_q, lo_q;
    logic [CNT_W-1:0] adv_idx;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    pix_class_t win     [3][3];
    pix_class_t win_nxt [3][3];
    pix_class_t new_cls, lb0_out, lb1_out;

    logic slot_free, accept, phantom, advance, produce;
    logic strong_nb, border, edge_bit;

    assign slot_free = strm.out_ready || !strm.out_valid;
    assign accept    = strm.in_valid && strm.in_ready;
    assign phantom   = (state == FLUSH) && slot_free && (adv_idx <= LAST_ADV);
    assign advance   = accept || phantom;
    assign produce   = advance && (adv_idx >= FIRST_OUT);
    assign new_cls   = accept ? classify(strm.in_pixel, hi_q, lo_q) : CLS_NONE;

    class_line_buffer #(.DEPTH(WIDTH)) u_lb0 (
        .clk(clk), .rst_n(rst_n), .advance(advance), .din(new_cls), .dout(lb0_out)
    );

    class_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .advance(advance), .din(lb0_out), .dout(lb1_out)
    );

    // Window after this advance: columns shift left, newest column enters on the right.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = lb1_out;
        win_nxt[1][2] = lb0_out;
        win_nxt[2][2] = new_cls;

        strong_nb = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1) && win_nxt[r][c] == CLS_STRONG) strong_nb = 1'b1;
            end
        end

        border   = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
        edge_bit = !border && ((win_nxt[1][1] == CLS_STRONG) ||
                               (win_nxt[1][1] == CLS_WEAK && strong_nb));
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            win <= win_nxt;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            hi_q           <= '0;
            lo_q           <= '0;
            adv_idx        <= '0;
            col            <= '0;
            row            <= '0;
            strm.out_valid <= 1'b0;
            strm.out_pixel <= '0;
            strm.out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                hi_q    <= high_thr;
                lo_q    <= low_thr;
                adv_idx <= '0;
                col     <= '0;
                row     <= '0;
            end
            if (advance) begin
                adv_idx <= adv_idx + 1'b1;
            end
            if (produce) begin
                strm.out_valid <= 1'b1;
                strm.out_pixel <= edge_bit ? EDGE_ON : 8'd0;
                strm.out_last  <= (adv_idx == LAST_ADV);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (strm.out_ready) begin
                strm.out_valid <= 1'b0;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        strm.in_ready = 1'b0;
        busy          = (state != IDLE);
        done          = (state == DONE);
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                strm.in_ready = slot_free;
                if (accept && adv_idx == LAST_IN) state_nxt = FLUSH;
            end
            FLUSH: if (strm.out_valid && strm.out_ready && strm.out_last) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hysteresis_threshold.sv
// Self-checking bench: a reference edge map is pushed to a scoreboard when each
// frame starts and popped on every output handshake.
module tb_hysteresis_threshold;
    import canny_pkg::*;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] high_thr = 8'd100;
    logic [7:0] low_thr = 8'd50;
    logic       busy, done;

    hysteresis_threshold_if #(.PIX_W(8)) strm ();

    hysteresis_threshold #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .high_thr(high_thr),
        .low_thr(low_thr), .strm(strm), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int frame [N];
    logic [8:0] sb [$];
    int out_cnt, done_cnt, done_cyc, last_cyc, first_valid_cyc, acc7_cyc;
    bit stop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cls(input int p, input int hi, input int lo);
        if (p >= hi) return 2;
        if (p >= lo) return 1;
        return 0;
    endfunction

    task automatic push_expected(input int hi, input int lo);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int v = 0;
                if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
                    int cc = cls(frame[r*W+c], hi, lo);
                    if (cc == 2) v = 255;
                    else if (cc == 1) begin
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++)
                                if ((dr != 0 || dc != 0) && cls(frame[(r+dr)*W+c+dc], hi, lo) == 2) v = 255;
                    end
                end
                sb.push_back({(r*W+c == N-1), v[7:0]});
            end
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) frame[i] = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (strm.out_valid && !strm.out_ready) check("in_ready_backpressure", strm.in_ready, 0);
            if (strm.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (strm.out_valid && strm.out_ready) begin
                if (sb.size() == 0) check("extra_output", 1, 0);
                else check($sformatf("out%0d{last,pix}", out_cnt), {strm.out_last, strm.out_pixel}, sb.pop_front());
                if (strm.out_last) last_cyc = cyc;
                out_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic begin_frame(input int hi, input int lo, input bit scramble);
        push_expected(hi, lo);
        out_cnt = 0; done_cnt = 0; last_cyc = -1; first_valid_cyc = -1; acc7_cyc = -100;
        @(posedge clk); #1;
        high_thr = hi[7:0]; low_thr = lo[7:0]; start = 1'b1; strm.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin
            high_thr = 8'd255;
            low_thr = 8'd255;
        end
    endtask

    task automatic feed(input int n, input bit gap);
        int i = 0;
        int tries = 0;
        bit acc;
        while (i < n && tries < 2000) begin
            strm.in_valid = gap ? (tries % 3 != 2) : 1'b1;
            strm.in_pixel = frame[i][7:0];
            tries++;
            @(negedge clk);
            acc = strm.in_valid && strm.in_ready;
            if (acc && i == W + 1) acc7_cyc = cyc;
            @(posedge clk); #1;
            if (acc) i++;
        end
        strm.in_valid = 1'b0;
        if (i < n) check("input_accept_timeout", i, n);
    endtask

    task automatic run_frame(input int hi, input int lo, input bit bp, input bit gap, input bit scramble);
        begin_frame(hi, lo, scramble);
        stop = 1'b0;
        fork
            begin
                int t = 0;
                feed(N, gap);
                while (done_cnt == 0 && t < 500) begin
                    @(posedge clk); #1;
                    t++;
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    strm.out_ready = bp ? ~strm.out_ready : 1'b1;
                end
            end
        join
        strm.out_ready = 1'b1;
        @(negedge clk);
        check("first_valid_latency", first_valid_cyc, acc7_cyc + 1);
        check("output_count", out_cnt, N);
        check("done_after_last", done_cyc, last_cyc + 1);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy, 0);
        sb.delete();
    endtask

    initial begin
        strm.in_valid = 1'b0;
        strm.in_pixel = '0;
        strm.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", strm.out_valid, 0);
        check("rst_in_ready", strm.in_ready, 0);
        check("rst_out_pixel", strm.out_pixel, 0);
        check("rst_out_last", strm.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        clear_frame();
        run_frame(100, 50, 0, 0, 0);

        clear_frame();
        frame[2*W+2] = 120;
        run_frame(100, 50, 0, 0, 0);

        clear_frame();
        frame[1*W+1] = 120; frame[2*W+2] = 60; frame[3*W+3] = 60;
        run_frame(100, 50, 0, 0, 0);

        clear_frame();
        frame[0] = 200; frame[1*W+1] = 60;
        run_frame(100, 50, 0, 0, 0);

        clear_frame();
        frame[1*W+1] = 120; frame[2*W+2] = 60; frame[3*W+3] = 60;
        run_frame(100, 50, 1, 1, 1);

        clear_frame();
        frame[2*W+2] = 60; frame[2*W+3] = 40;
        run_frame(50, 200, 0, 0, 0);

        clear_frame();
        frame[2*W+2] = 120;
        begin_frame(100, 50, 0);
        feed(12, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", strm.out_valid, 0);
        check("midrst_in_ready", strm.in_ready, 0);
        check("midrst_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, 0);

        run_frame(100, 50, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
